line_memory_responder: RTL

//  Main-memory responder for the cache's line-fill interface: the target side of

---
 rtl/line_memory_responder_if.sv | 28 ++
 rtl/line_memory_responder.sv | 112 +++++++++++
 2 files changed

// File: rtl/line_memory_responder_if.sv
// Line-fill bus between the cache (master) and the main-memory responder (slave).
// Request is level-held. The responder answers with a one-cycle mem_done.
interface line_memory_responder_if #(
   parameter int Word_Size  = 32,
   parameter int Block_Size = 4
);
   localparam int LINE_W = Word_Size * Block_Size;

   logic                  read_Mem;
   logic                  write_Mem;
   logic [31:0]           Addr_Mem;
   logic [LINE_W-1:0]     Wdata_Mem;
   logic [Block_Size-1:0] Wmask_Mem;
   logic [LINE_W-1:0]     Rdata_Mem;
   logic                  ready_mem;
   logic                  mem_done;
   logic                  err_proto;

   modport master (
      output read_Mem, write_Mem, Addr_Mem, Wdata_Mem, Wmask_Mem,
      input  Rdata_Mem, ready_mem, mem_done, err_proto
   );

   modport slave (
      input  read_Mem, write_Mem, Addr_Mem, Wdata_Mem, Wmask_Mem,
      output Rdata_Mem, ready_mem, mem_done, err_proto
   );
endinterface

// File: rtl/line_memory_responder.sv
// Fixed-latency main-memory responder. It serves one full-line read or one word-masked
// line write per request and waits for the request to drop before it re-arms.
module line_memory_responder #(
   parameter int Word_Size   = 32,
   parameter int Block_Size  = 4,
   parameter int Depth_Lines = 256,
   parameter int Latency     = 5
) (
   input logic                     clk,
   input logic                     reset,
   line_memory_responder_if.slave  mem
);
   localparam int LINE_W = Word_Size * Block_Size;
   localparam int IDX    = $clog2(Depth_Lines);
   localparam int CW     = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

   typedef logic [Block_Size-1:0][Word_Size-1:0] line_t;

   line_t                 mem_q [Depth_Lines];
   state_t                state_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IDX-1:0]        idx_q, idx_in;
   logic                  op_wr_q;
   line_t                 wdata_q;
   logic [Block_Size-1:0] wmask_q;
   logic [LINE_W-1:0]     rdata_q;
   logic                  ready_q, done_q, err_q;
   logic                  req, commit;

   assign idx_in = mem.Addr_Mem[IDX+3:4];
   assign req    = mem.read_Mem | mem.write_Mem;
   assign cnt_d  = cnt_q - CW'(1);

   // Reset in the DONE cycle must also cancel that cycle's commit.
   assign commit = (state_q == DONE) && op_wr_q && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         op_wr_q <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (req) begin
                  idx_q   <= idx_in;
                  op_wr_q <= mem.write_Mem & ~mem.read_Mem;
                  wdata_q <= mem.Wdata_Mem;
                  wmask_q <= mem.Wmask_Mem;
                  err_q   <= err_q | (mem.read_Mem & mem.write_Mem);
                  ready_q <= 1'b0;
                  cnt_q   <= CW'(Latency - 1);
                  if (Latency == 1) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     if (mem.read_Mem) rdata_q <= mem_q[idx_in];
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               cnt_q <= cnt_d;
               if (cnt_d == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  if (!op_wr_q) rdata_q <= mem_q[idx_q];
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= RELEASE;
            end
            RELEASE: begin
               // A request still held from the last transaction must not be served again.
               if (!req) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The array is never cleared, so lines that have not been written read as X.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int w = 0; w < Block_Size; w++) begin
            if (wmask_q[w]) mem_q[idx_q][w] <= wdata_q[w];
         end
      end
   end

   logic unused_addr;
   assign unused_addr = ^{mem.Addr_Mem[31:IDX+4], mem.Addr_Mem[3:0]};

   assign mem.Rdata_Mem = rdata_q;
   assign mem.ready_mem = ready_q;
   assign mem.mem_done  = done_q;
   assign mem.err_proto = err_q;
endmodule
